rename_regfile: RTL and testbench
=================================

// Module: rename_regfile
// PURPOSE
//  Architectural register file with rename table (ready bit + ROB tag per reg) for the Tomasulo core.
//  Serves NUM_RD decode read ports with commit-bus forwarding, records dispatch renames, applies ROB commits.
//  Adds branch checkpoints over rename state for selective rollback; sits between decoder/dispatch and ROB.
// PARAMETERS
//  XLEN      32  register/data width
//  NUM_REGS  32  architectural registers (x0 hardwired 0)
//  REG_W     5   register index width, clog2(NUM_REGS)
//  ROB_W     4   ROB tag width
//  NUM_RD    2   decode read ports
//  NUM_CKPT  4   rename checkpoints (used only with RF_CKPT_EN)
// PORTS
//  clk            in   1              clock
//  rst_n          in   1              reset: one clock; asynchronous, active-low
//  rdy            in   1              global ready; 0 = stall state updates
//  roll           in   1              full mispredict flush
//  rd_en          in   NUM_RD         port p requests read
//  rd_idx         in   NUM_RD*REG_W   source index per port
//  rd_valid       out  NUM_RD         port has a live operand (= rd_en)
//  rd_ready       out  NUM_RD         operand value available
//  rd_data        out  NUM_RD*XLEN    value if ready, else zero-extended ROB tag
//  dis_en         in   1              dispatch renames dis_rd
//  dis_rd         in   REG_W          destination reg
//  dis_tag        in   ROB_W          ROB entry of dispatched instr
//  cmt_en         in   1              ROB commit
//  cmt_tag        in   ROB_W          committing ROB entry
//  cmt_rd         in   REG_W          committed destination
//  cmt_val        in   XLEN           committed value
//  ckpt_alloc     in   1              take snapshot (branch dispatch)
//  ckpt_id        out  clog2(NUM_CKPT) lowest free checkpoint id (comb.)
//  ckpt_full      out  1              no free checkpoint; ckpt_alloc ignored
//  ckpt_release   in   1              branch resolved correct; free rel_id
//  rel_id         in   clog2(NUM_CKPT) checkpoint to free
//  ckpt_restore   in   1              branch mispredicted; restore res_id
//  res_id         in   clog2(NUM_CKPT) checkpoint to restore
// BEHAVIOUR
//  Reset: all val=0, ready=1, tag=0, checkpoints free, masks 0. Outputs comb.: rd_* =0 when rd_en=0.
//  Read (comb., 0 latency): ready[r] -> val[r]; elif cmt_en && cmt_tag==tag[r] -> cmt_val, ready=1;
//   else ready=0, data={0,tag[r]}. x0 always ready, data 0.
//  Priority per edge: rst_n > roll > ckpt_restore > !rdy(hold all) > normal. roll/restore act regardless of rdy.
//  Commit (rd!=0): val[rd]<=cmt_val; ready[rd]<=1 only if tag[rd]==cmt_tag and rd!=dis_rd this cycle.
//  Dispatch (rd!=0): tag<=dis_tag, ready<=0; wins over same-cycle commit to same rd.
//  roll: all ready<=1, all checkpoints freed; same-cycle commit value still written.
//  Commit into snapshots: every valid ckpt with snap_tag[rd]==cmt_tag sets snap_ready[rd].
//  Alloc: snapshot = ready/tag after this cycle's commit, excluding this cycle's dispatch;
//   dep mask[new] = currently valid set; alloc with ckpt_full = no-op.
//  Release j: valid[j]<=0, bit j cleared in all masks. Release of free id = no-op.
//  Restore k: ready/tag <= snapshot k (+ same-cycle commit); dispatch/alloc same cycle ignored;
//   frees k and every j with mask[j][k]=1 (younger). Restore+release same id: restore wins.
// CONFIGURATION
//  RF_CKPT_EN defined: checkpoint logic as above.
//  Undefined: no snapshot storage; ckpt_full=1, ckpt_id=0, release/restore inputs ignored; roll only recovery.
// STRUCTURE
//  define.v: REG_INDEX_RANGE, ROB_INDEX_RANGE, TRUE/FALSE, CKPT id width macros.
//  Sub-module rf_ckpt_alloc: free-list priority encoder, valid bits, dependency masks, younger-free on restore.
// TESTING
//  Reset mid-run: rst_n low async -> all rd_ready=1, rd_data=0 before next edge.
//  dis x5 tag3; read x5 -> ready=0,data=3; cmt tag3 val 0xABCD same cycle -> ready=1,data=0xABCD.
//  dis x7 tag1, dis x7 tag2, cmt x7 tag1 -> val=tag1 value, x7 still not ready (tag 2).
//  Same-cycle cmt x4 tag5 + dis x4 tag6 -> x4 not ready, tag 6, val updated.
//  alloc ck0, dis x9 tag4, alloc ck1, restore ck0 -> x9 ready, ck0/ck1 free, ckpt_id=0.
//  fill NUM_CKPT -> ckpt_full=1, extra alloc ignored; roll -> all free, all regs ready.

Source files
------------

// File: rtl/rename_regfile_pkg.sv
// Shared widths, types and helpers for the rename register file.
// Checkpoint logic is compiled in only when RF_CKPT_EN is defined.
package rename_regfile_pkg;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int ROB_W    = 4;
    localparam int NUM_RD   = 2;
    localparam int NUM_CKPT = 4;
    localparam int CKPT_W   = $clog2(NUM_CKPT);

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [ROB_W-1:0]  rob_tag_t;
    typedef logic [XLEN-1:0]   xlen_t;
    typedef logic [CKPT_W-1:0] ckpt_id_t;

    // A not-ready operand is returned as its producing ROB tag, zero-extended.
    function automatic xlen_t tag_to_data(input rob_tag_t tag);
        return {{(XLEN-ROB_W){1'b0}}, tag};
    endfunction
endpackage

// File: rtl/rename_regfile_if.sv
// Decode/dispatch/commit/checkpoint bus of the rename register file.
interface rename_regfile_if;
    import rename_regfile_pkg::*;

    logic                     rdy;
    logic                     roll;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*REG_W-1:0]  rd_idx;
    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD-1:0]        rd_ready;
    logic [NUM_RD*XLEN-1:0]   rd_data;
    logic                     dis_en;
    reg_idx_t                 dis_rd;
    rob_tag_t                 dis_tag;
    logic                     cmt_en;
    rob_tag_t                 cmt_tag;
    reg_idx_t                 cmt_rd;
    xlen_t                    cmt_val;
    logic                     ckpt_alloc;
    ckpt_id_t                 ckpt_id;
    logic                     ckpt_full;
    logic                     ckpt_release;
    ckpt_id_t                 rel_id;
    logic                     ckpt_restore;
    ckpt_id_t                 res_id;

    modport master (
        output rdy, roll, rd_en, rd_idx, dis_en, dis_rd, dis_tag,
               cmt_en, cmt_tag, cmt_rd, cmt_val,
               ckpt_alloc, ckpt_release, rel_id, ckpt_restore, res_id,
        input  rd_valid, rd_ready, rd_data, ckpt_id, ckpt_full
    );
    modport slave (
        input  rdy, roll, rd_en, rd_idx, dis_en, dis_rd, dis_tag,
               cmt_en, cmt_tag, cmt_rd, cmt_val,
               ckpt_alloc, ckpt_release, rel_id, ckpt_restore, res_id,
        output rd_valid, rd_ready, rd_data, ckpt_id, ckpt_full
    );
endinterface

// File: rtl/rf_ckpt_alloc.sv
// Checkpoint free list: valid bits, lowest-free encoder and per-checkpoint
// dependency masks so a restore also frees every younger checkpoint.
module rf_ckpt_alloc
    import rename_regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                roll,
    input  logic                alloc_fire,
    input  logic                release_en,
    input  ckpt_id_t            rel_id,
    input  logic                restore_en,
    input  ckpt_id_t            res_id,
    output logic [NUM_CKPT-1:0] valid,
    output ckpt_id_t            free_id,
    output logic                full
);
    logic [NUM_CKPT-1:0] valid_q, valid_d, freed;
    logic [NUM_CKPT-1:0] mask_q [NUM_CKPT];
    logic [NUM_CKPT-1:0] mask_d [NUM_CKPT];

    assign valid = valid_q;
    assign full  = &valid_q;

    always_comb begin
        free_id = '0;
        for (int j = NUM_CKPT-1; j >= 0; j--)
            if (!valid_q[j]) free_id = ckpt_id_t'(j);
    end

    always_comb begin
        freed = '0;
        if (roll) begin
            freed = '1;
        end else if (restore_en) begin
            // mask[j][k] set means j was taken while k was live, i.e. j is younger
            for (int j = 0; j < NUM_CKPT; j++)
                if (ckpt_id_t'(j) == res_id || mask_q[j][res_id]) freed[j] = 1'b1;
            if (rdy && release_en && rel_id != res_id) freed[rel_id] = 1'b1;
        end else if (rdy && release_en) begin
            freed[rel_id] = 1'b1;
        end
        valid_d = valid_q & ~freed;
        for (int i = 0; i < NUM_CKPT; i++)
            mask_d[i] = freed[i] ? '0 : (mask_q[i] & ~freed);
        if (alloc_fire) begin
            valid_d[free_id] = 1'b1;
            mask_d[free_id]  = valid_q & ~freed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_CKPT; i++) mask_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < NUM_CKPT; i++) mask_q[i] <= mask_d[i];
        end
    end
endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename table, commit forwarding and,
// when RF_CKPT_EN is defined, branch checkpoints with selective rollback.
module rename_regfile
    import rename_regfile_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    rename_regfile_if.slave bus
);
    xlen_t               val_q [NUM_REGS];
    xlen_t               val_d [NUM_REGS];
    rob_tag_t            tag_q [NUM_REGS];
    rob_tag_t            tag_d [NUM_REGS];
    logic [NUM_REGS-1:0] ready_q, ready_d, ready_cmt;
    logic [NUM_REGS-1:0] sel_ready;
    rob_tag_t            sel_tag [NUM_REGS];
    logic                commit_act, dispatch_act, restore_act;
    logic [NUM_RD-1:0]       rd_ready_c;
    logic [NUM_RD*XLEN-1:0]  rd_data_c;

    // Commits still land during a flush or restore even while stalled.
    assign commit_act   = bus.cmt_en && (bus.cmt_rd != '0) && (bus.rdy || bus.roll || restore_act);
    assign dispatch_act = bus.dis_en && (bus.dis_rd != '0) && bus.rdy && !bus.roll && !restore_act;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cmt
        assign ready_cmt[gi] = ready_q[gi] |
            (commit_act && bus.cmt_rd == REG_W'(gi) && tag_q[gi] == bus.cmt_tag);
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        reg_idx_t src;
        logic     fwd;
        assign src = bus.rd_idx[gi*REG_W +: REG_W];
        assign fwd = bus.cmt_en && (bus.cmt_tag == tag_q[src]);
        assign rd_ready_c[gi] = bus.rd_en[gi] && (src == '0 || ready_q[src] || fwd);
        assign rd_data_c[gi*XLEN +: XLEN] =
            (!bus.rd_en[gi] || src == '0) ? '0 :
            ready_q[src] ? val_q[src] :
            fwd ? bus.cmt_val : tag_to_data(tag_q[src]);
    end

    assign bus.rd_valid = bus.rd_en;
    assign bus.rd_ready = rd_ready_c;
    assign bus.rd_data  = rd_data_c;

`ifdef RF_CKPT_EN
    logic [NUM_REGS-1:0] snap_ready_q [NUM_CKPT];
    logic [NUM_REGS-1:0] snap_ready_d [NUM_CKPT];
    rob_tag_t            snap_tag_q   [NUM_CKPT][NUM_REGS];
    rob_tag_t            snap_tag_d   [NUM_CKPT][NUM_REGS];
    logic [NUM_CKPT-1:0] ckpt_valid;
    ckpt_id_t            alloc_id;
    logic                alloc_full, alloc_fire;

    assign restore_act = bus.ckpt_restore;
    assign alloc_fire  = bus.ckpt_alloc && !alloc_full && bus.rdy && !bus.roll && !restore_act;
    assign bus.ckpt_id   = alloc_id;
    assign bus.ckpt_full = alloc_full;

    rf_ckpt_alloc u_alloc (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy        (bus.rdy),
        .roll       (bus.roll),
        .alloc_fire (alloc_fire),
        .release_en (bus.ckpt_release),
        .rel_id     (bus.rel_id),
        .restore_en (restore_act),
        .res_id     (bus.res_id),
        .valid      (ckpt_valid),
        .free_id    (alloc_id),
        .full       (alloc_full)
    );

    // A new snapshot sees this cycle's commit but not this cycle's dispatch.
    always_comb begin
        for (int j = 0; j < NUM_CKPT; j++) begin
            snap_ready_d[j] = snap_ready_q[j];
            for (int r = 0; r < NUM_REGS; r++) snap_tag_d[j][r] = snap_tag_q[j][r];
            if (alloc_fire && alloc_id == ckpt_id_t'(j)) begin
                snap_ready_d[j] = ready_cmt;
                for (int r = 0; r < NUM_REGS; r++) snap_tag_d[j][r] = tag_q[r];
            end else if (ckpt_valid[j] && commit_act &&
                         snap_tag_q[j][bus.cmt_rd] == bus.cmt_tag) begin
                snap_ready_d[j][bus.cmt_rd] = 1'b1;
            end
        end
    end

    assign sel_ready = snap_ready_d[bus.res_id];
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
        assign sel_tag[gi] = snap_tag_q[bus.res_id][gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_CKPT; j++) begin
                snap_ready_q[j] <= '1;
                for (int r = 0; r < NUM_REGS; r++) snap_tag_q[j][r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_CKPT; j++) begin
                snap_ready_q[j] <= snap_ready_d[j];
                for (int r = 0; r < NUM_REGS; r++) snap_tag_q[j][r] <= snap_tag_d[j][r];
            end
        end
    end
`else
    logic unused_ckpt;
    assign unused_ckpt   = ^{bus.ckpt_alloc, bus.ckpt_release, bus.rel_id,
                             bus.ckpt_restore, bus.res_id};
    assign restore_act   = 1'b0;
    assign bus.ckpt_id   = '0;
    assign bus.ckpt_full = 1'b1;
    assign sel_ready     = '1;
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
        assign sel_tag[gi] = '0;
    end
`endif

    // Dispatch is applied after commit so it wins on the same destination.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            val_d[r] = val_q[r];
            tag_d[r] = tag_q[r];
        end
        ready_d = ready_q;
        if (commit_act) val_d[bus.cmt_rd] = bus.cmt_val;
        if (bus.roll) begin
            ready_d = '1;
        end else if (restore_act) begin
            ready_d = sel_ready;
            for (int r = 0; r < NUM_REGS; r++) tag_d[r] = sel_tag[r];
        end else if (bus.rdy) begin
            ready_d = ready_cmt;
            if (dispatch_act) begin
                tag_d[bus.dis_rd]   = bus.dis_tag;
                ready_d[bus.dis_rd] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= '1;
            for (int r = 0; r < NUM_REGS; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
        end else begin
            ready_q <= ready_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                val_q[r] <= val_d[r];
                tag_q[r] <= tag_d[r];
            end
        end
    end
endmodule

// File: tb/tb_rename_regfile.sv
// Directed self-checking bench for rename_regfile; checkpoint scenarios
// follow the RF_CKPT_EN build setting.
module tb_rename_regfile;
    import rename_regfile_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;

    rename_regfile_if bus_if ();

    rename_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus_if.rdy = 1'b1; bus_if.roll = 1'b0;
        bus_if.rd_en = '0; bus_if.rd_idx = '0;
        bus_if.dis_en = 1'b0; bus_if.dis_rd = '0; bus_if.dis_tag = '0;
        bus_if.cmt_en = 1'b0; bus_if.cmt_tag = '0; bus_if.cmt_rd = '0; bus_if.cmt_val = '0;
        bus_if.ckpt_alloc = 1'b0; bus_if.ckpt_release = 1'b0; bus_if.rel_id = '0;
        bus_if.ckpt_restore = 1'b0; bus_if.res_id = '0;
    endtask

    task automatic rd(input int p, input logic [REG_W-1:0] idx);
        bus_if.rd_en[p] = 1'b1;
        bus_if.rd_idx[p*REG_W +: REG_W] = idx;
    endtask

    task automatic dispatch(input logic [REG_W-1:0] rdi, input logic [ROB_W-1:0] tag);
        bus_if.dis_en = 1'b1; bus_if.dis_rd = rdi; bus_if.dis_tag = tag;
        step(); clr();
    endtask

    function automatic logic [XLEN-1:0] data_of(input int p);
        logic [NUM_RD*XLEN-1:0] d;
        d = bus_if.rd_data;
        return d[p*XLEN +: XLEN];
    endfunction

    task automatic test_reset();
        clr(); rst_n = 1'b0;
        step(); step();
        rd(0, 5'd5); rd(1, 5'd0); #1;
        checks++; if (bus_if.rd_ready !== 2'b11) $display("FAIL reset_ready: got %b expected 11", bus_if.rd_ready); else passes++;
        checks++; if (bus_if.rd_valid !== 2'b11) $display("FAIL reset_valid: got %b expected 11", bus_if.rd_valid); else passes++;
        checks++; if (bus_if.rd_data !== '0) $display("FAIL reset_data: got %h expected 0", bus_if.rd_data); else passes++;
`ifdef RF_CKPT_EN
        checks++; if (bus_if.ckpt_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus_if.ckpt_full); else passes++;
`else
        checks++; if (bus_if.ckpt_full !== 1'b1) $display("FAIL reset_full: got %b expected 1", bus_if.ckpt_full); else passes++;
`endif
        bus_if.rd_en = 2'b00; #1;
        checks++; if ({bus_if.rd_valid, bus_if.rd_ready} !== 4'b0000) $display("FAIL reset_idle: got %b expected 0000", {bus_if.rd_valid, bus_if.rd_ready}); else passes++;
        rst_n = 1'b1; clr(); step();
        $display("test_reset done");
    endtask

    task automatic test_forward();
        dispatch(5'd5, 4'd3);
        rd(0, 5'd5); #1;
        checks++; if (bus_if.rd_ready[0] !== 1'b0) $display("FAIL fwd_notready: got %b expected 0", bus_if.rd_ready[0]); else passes++;
        checks++; if (data_of(0) !== 32'd3) $display("FAIL fwd_tag: got %h expected 3", data_of(0)); else passes++;
        bus_if.cmt_en = 1'b1; bus_if.cmt_tag = 4'd3; bus_if.cmt_rd = 5'd5; bus_if.cmt_val = 32'hABCD; #1;
        checks++; if (bus_if.rd_ready[0] !== 1'b1 || data_of(0) !== 32'hABCD) $display("FAIL fwd_bypass: got %b/%h expected 1/0000abcd", bus_if.rd_ready[0], data_of(0)); else passes++;
        step(); clr(); rd(0, 5'd5); #1;
        checks++; if (bus_if.rd_ready[0] !== 1'b1 || data_of(0) !== 32'hABCD) $display("FAIL fwd_commit: got %b/%h expected 1/0000abcd", bus_if.rd_ready[0], data_of(0)); else passes++;
        $display("test_forward done");
    endtask

    task automatic test_double_dispatch();
        clr();
        dispatch(5'd7, 4'd1);
        dispatch(5'd7, 4'd2);
        bus_if.cmt_en = 1'b1; bus_if.cmt_tag = 4'd1; bus_if.cmt_rd = 5'd7; bus_if.cmt_val = 32'h1111;
        rd(1, 5'd7); #1;
        checks++; if (bus_if.rd_ready[1] !== 1'b0 || data_of(1) !== 32'd2) $display("FAIL dbl_nofwd: got %b/%h expected 0/2", bus_if.rd_ready[1], data_of(1)); else passes++;
        step(); clr(); rd(1, 5'd7); #1;
        checks++; if (bus_if.rd_ready[1] !== 1'b0 || data_of(1) !== 32'd2) $display("FAIL dbl_stale: got %b/%h expected 0/2", bus_if.rd_ready[1], data_of(1)); else passes++;
        bus_if.cmt_en = 1'b1; bus_if.cmt_tag = 4'd2; bus_if.cmt_rd = 5'd7; bus_if.cmt_val = 32'h2222;
        step(); clr(); rd(1, 5'd7); #1;
        checks++; if (bus_if.rd_ready[1] !== 1'b1 || data_of(1) !== 32'h2222) $display("FAIL dbl_final: got %b/%h expected 1/2222", bus_if.rd_ready[1], data_of(1)); else passes++;
        $display("test_double_dispatch done");
    endtask

    task automatic test_same_cycle();
        clr();
        dispatch(5'd4, 4'd5);
        bus_if.cmt_en = 1'b1; bus_if.cmt_tag = 4'd5; bus_if.cmt_rd = 5'd4; bus_if.cmt_val = 32'h44;
        bus_if.dis_en = 1'b1; bus_if.dis_rd = 5'd4; bus_if.dis_tag = 4'd6;
        rd(0, 5'd4); #1;
        checks++; if (bus_if.rd_ready[0] !== 1'b1 || data_of(0) !== 32'h44) $display("FAIL same_bypass: got %b/%h expected 1/44", bus_if.rd_ready[0], data_of(0)); else passes++;
        step(); clr(); rd(0, 5'd4); #1;
        checks++; if (bus_if.rd_ready[0] !== 1'b0 || data_of(0) !== 32'd6) $display("FAIL same_dispatch_wins: got %b/%h expected 0/6", bus_if.rd_ready[0], data_of(0)); else passes++;
        $display("test_same_cycle done");
    endtask

    task automatic test_stall_and_x0();
        clr();
        bus_if.rdy = 1'b0;
        bus_if.dis_en = 1'b1; bus_if.dis_rd = 5'd10; bus_if.dis_tag = 4'd7;
        step(); clr(); rd(0, 5'd10); #1;
        checks++; if (bus_if.rd_ready[0] !== 1'b1 || data_of(0) !== 32'd0) $display("FAIL stall_hold: got %b/%h expected 1/0", bus_if.rd_ready[0], data_of(0)); else passes++;
        clr();
        dispatch(5'd0, 4'd9);
        bus_if.cmt_en = 1'b1; bus_if.cmt_tag = 4'd0; bus_if.cmt_rd = 5'd0; bus_if.cmt_val = 32'hDEAD;
        rd(1, 5'd0); #1;
        checks++; if (bus_if.rd_ready[1] !== 1'b1 || data_of(1) !== 32'd0) $display("FAIL x0_zero: got %b/%h expected 1/0", bus_if.rd_ready[1], data_of(1)); else passes++;
        step(); clr();
        $display("test_stall_and_x0 done");
    endtask

    task automatic test_ckpt();
        clr();
`ifdef RF_CKPT_EN
        checks++; if (bus_if.ckpt_id !== 2'd0) $display("FAIL ck_id0: got %0d expected 0", bus_if.ckpt_id); else passes++;
        bus_if.ckpt_alloc = 1'b1; step(); clr();
        dispatch(5'd9, 4'd4);
        checks++; if (bus_if.ckpt_id !== 2'd1) $display("FAIL ck_id1: got %0d expected 1", bus_if.ckpt_id); else passes++;
        bus_if.ckpt_alloc = 1'b1; step(); clr();
        bus_if.ckpt_restore = 1'b1; bus_if.res_id = 2'd0; step(); clr();
        rd(0, 5'd9); #1;
        checks++; if (bus_if.rd_ready[0] !== 1'b1 || data_of(0) !== 32'd0) $display("FAIL ck_restore_reg: got %b/%h expected 1/0", bus_if.rd_ready[0], data_of(0)); else passes++;
        checks++; if (bus_if.ckpt_id !== 2'd0) $display("FAIL ck_restore_id: got %0d expected 0", bus_if.ckpt_id); else passes++;
        bus_if.ckpt_alloc = 1'b1; step(); clr();
        checks++; if (bus_if.ckpt_id !== 2'd1) $display("FAIL ck_younger_freed: got %0d expected 1", bus_if.ckpt_id); else passes++;
`else
        bus_if.ckpt_alloc = 1'b1; step(); clr();
        checks++; if (bus_if.ckpt_full !== 1'b1 || bus_if.ckpt_id !== 2'd0) $display("FAIL ck_disabled: got %b/%0d expected 1/0", bus_if.ckpt_full, bus_if.ckpt_id); else passes++;
        dispatch(5'd9, 4'd4);
        bus_if.ckpt_restore = 1'b1; bus_if.res_id = 2'd0; step(); clr();
        rd(0, 5'd9); #1;
        checks++; if (bus_if.rd_ready[0] !== 1'b0 || data_of(0) !== 32'd4) $display("FAIL ck_restore_ignored: got %b/%h expected 0/4", bus_if.rd_ready[0], data_of(0)); else passes++;
`endif
        clr();
        $display("test_ckpt done");
    endtask

    task automatic test_full();
        clr();
`ifdef RF_CKPT_EN
        for (int i = 1; i < NUM_CKPT; i++) begin
            checks++; if (bus_if.ckpt_id !== ckpt_id_t'(i)) $display("FAIL full_fill_id: got %0d expected %0d", bus_if.ckpt_id, i); else passes++;
            bus_if.ckpt_alloc = 1'b1; step(); clr();
        end
        checks++; if (bus_if.ckpt_full !== 1'b1) $display("FAIL full_flag: got %b expected 1", bus_if.ckpt_full); else passes++;
        bus_if.ckpt_alloc = 1'b1; step(); clr();
        bus_if.ckpt_release = 1'b1; bus_if.rel_id = 2'd2; step(); clr();
        checks++; if (bus_if.ckpt_full !== 1'b0 || bus_if.ckpt_id !== 2'd2) $display("FAIL full_release: got %b/%0d expected 0/2", bus_if.ckpt_full, bus_if.ckpt_id); else passes++;
`else
        bus_if.ckpt_release = 1'b1; bus_if.rel_id = 2'd2; step(); clr();
        checks++; if (bus_if.ckpt_full !== 1'b1) $display("FAIL full_disabled: got %b expected 1", bus_if.ckpt_full); else passes++;
`endif
        $display("test_full done");
    endtask

    task automatic test_roll();
        clr();
        bus_if.roll = 1'b1; bus_if.rdy = 1'b0;
        bus_if.cmt_en = 1'b1; bus_if.cmt_tag = 4'd6; bus_if.cmt_rd = 5'd4; bus_if.cmt_val = 32'h77;
        step(); clr();
        rd(0, 5'd4); rd(1, 5'd9); #1;
        checks++; if (bus_if.rd_ready !== 2'b11) $display("FAIL roll_ready: got %b expected 11", bus_if.rd_ready); else passes++;
        checks++; if (data_of(0) !== 32'h77) $display("FAIL roll_cmt_val: got %h expected 77", data_of(0)); else passes++;
        checks++; if (data_of(1) !== 32'd0) $display("FAIL roll_x9: got %h expected 0", data_of(1)); else passes++;
`ifdef RF_CKPT_EN
        checks++; if (bus_if.ckpt_full !== 1'b0 || bus_if.ckpt_id !== 2'd0) $display("FAIL roll_ckpt: got %b/%0d expected 0/0", bus_if.ckpt_full, bus_if.ckpt_id); else passes++;
`endif
        clr();
        $display("test_roll done");
    endtask

    task automatic test_reset_mid();
        clr();
        dispatch(5'd12, 4'd3);
        rd(0, 5'd12); rd(1, 5'd4); #1;
        checks++; if (bus_if.rd_ready !== 2'b10 || data_of(0) !== 32'd3) $display("FAIL mid_pre: got %b/%h expected 10/3", bus_if.rd_ready, data_of(0)); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_if.rd_ready !== 2'b11) $display("FAIL mid_async_ready: got %b expected 11", bus_if.rd_ready); else passes++;
        checks++; if (bus_if.rd_data !== '0) $display("FAIL mid_async_data: got %h expected 0", bus_if.rd_data); else passes++;
        step(); rst_n = 1'b1; clr(); step();
        $display("test_reset_mid done");
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_forward();
        test_double_dispatch();
        test_same_cycle();
        test_stall_and_x0();
        test_ckpt();
        test_full();
        test_roll();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
